// File: rtl/controller_pkg.sv
// Shared definitions for the host-side gamepad poller: FSM states, button
// bit positions within a committed byte, and legal parameter ranges.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        LOW,
        HIGH,
        COMMIT
    } poll_state_t;

    localparam int unsigned BTN_W = 8;

    // First serial bit lands in bit 7.
    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_B      = 6;
    localparam int unsigned BTN_SELECT = 5;
    localparam int unsigned BTN_START  = 4;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 0;

    localparam int unsigned HALF_PERIOD_MIN  = 4;
    localparam int unsigned HALF_PERIOD_MAX  = 255;
    localparam int unsigned LATCH_HALVES_MIN = 1;
    localparam int unsigned LATCH_HALVES_MAX = 255;

endpackage

// File: rtl/sync2_m.sv
// Two-flop synchroniser for an asynchronous pad input, with a selectable
// reset value so an idle active-low line resets to its inactive level.
module sync2_m #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/controller_poller_m.sv
// Host-side serial gamepad reader: latches two shift-register controllers,
// clocks out 8 bits from each and commits both button bytes atomically.
module controller_poller_m
    import controller_pkg::*;
#(
    parameter int unsigned HALF_PERIOD  = 8,
    parameter int unsigned LATCH_HALVES = 2
) (
    input  logic       clk_12_5875,
    input  logic       rst,
    input  logic       start,
    output logic       controller_clk,
    output logic       controller_clk_out_enable,
    output logic       controller_latch,
    input  logic       controller_1_data_in_B,
    input  logic       controller_2_data_in_B,
    output logic [7:0] controller_1_buttons_out,
    output logic [7:0] controller_2_buttons_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(LATCH_HALVES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BTN_W - 1);

    if ((HALF_PERIOD < HALF_PERIOD_MIN) || (HALF_PERIOD > HALF_PERIOD_MAX)) begin : g_half_period_check
        $error("controller_poller_m: HALF_PERIOD must be within 4..255");
    end
    if ((LATCH_HALVES < LATCH_HALVES_MIN) || (LATCH_HALVES > LATCH_HALVES_MAX)) begin : g_latch_halves_check
        $error("controller_poller_m: LATCH_HALVES must be within 1..255");
    end

    poll_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [BTN_W-1:0] shadow1_q, shadow1_d;
    logic [BTN_W-1:0] shadow2_q, shadow2_d;
    logic [BTN_W-1:0] buttons1_q, buttons1_d;
    logic [BTN_W-1:0] buttons2_q, buttons2_d;
    logic             clk_q, clk_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic data1_b;
    logic data2_b;
    logic tick;

    sync2_m #(.RESET_VAL(1'b1)) u_sync1 (
        .clk_i (clk_12_5875),
        .rst_i (rst),
        .d_i   (controller_1_data_in_B),
        .q_o   (data1_b)
    );

    sync2_m #(.RESET_VAL(1'b1)) u_sync2 (
        .clk_i (clk_12_5875),
        .rst_i (rst),
        .d_i   (controller_2_data_in_B),
        .q_o   (data2_b)
    );

    assign tick = (cnt_q == CNT_LAST);

    // Next state; pad outputs are decoded from the next state so they are
    // registered yet aligned with the state they belong to.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        bit_d      = bit_q;
        shadow1_d  = shadow1_q;
        shadow2_d  = shadow2_q;
        buttons1_d = buttons1_q;
        buttons2_d = buttons2_q;

        if ((state_q == IDLE) || (state_q == COMMIT) || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LATCH;
                    half_d  = '0;
                    bit_d   = '0;
                end
            end
            LATCH: begin
                if (tick) begin
                    if (half_q == HALF_LAST) begin
                        state_d = GAP;
                    end else begin
                        half_d = half_q + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = LOW;
                    bit_d   = '0;
                end
            end
            LOW: begin
                if (tick) begin
                    shadow1_d = {shadow1_q[BTN_W-2:0], ~data1_b};
                    shadow2_d = {shadow2_q[BTN_W-2:0], ~data2_b};
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        // Load on the edge into COMMIT so bytes and done appear together.
                        state_d    = COMMIT;
                        buttons1_d = shadow1_q;
                        buttons2_d = shadow2_q;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = LOW;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        clk_d   = (state_d == HIGH);
        latch_d = (state_d == LATCH);
        busy_d  = (state_d == LATCH) || (state_d == GAP) ||
                  (state_d == LOW)   || (state_d == HIGH);
        done_d  = (state_d == COMMIT);
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= '0;
            bit_q      <= '0;
            shadow1_q  <= '0;
            shadow2_q  <= '0;
            buttons1_q <= '0;
            buttons2_q <= '0;
            clk_q      <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            shadow1_q  <= shadow1_d;
            shadow2_q  <= shadow2_d;
            buttons1_q <= buttons1_d;
            buttons2_q <= buttons2_d;
            clk_q      <= clk_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign controller_clk            = clk_q;
    assign controller_latch          = latch_q;
    assign busy                      = busy_q;
    assign controller_clk_out_enable = busy_q;
    assign done                      = done_q;
    assign controller_1_buttons_out  = buttons1_q;
    assign controller_2_buttons_out  = buttons2_q;

endmodule

// File: tb/tb_controller_poller_m.sv
// Bench for controller_poller_m: behavioural shift-register controllers feed
// the poller; expected button bytes go through a scoreboard queue.
module tb_controller_poller_m;
    import controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_f = 1'b0;
    logic       ctl_clk, ctl_oe, ctl_latch, busy, done;
    logic       f_clk, f_oe, f_latch, f_busy, f_done;
    logic [7:0] btn1, btn2, f_btn1, f_btn2;
    logic [7:0] m1_btn = 8'h00, m2_btn = 8'h00, m3_btn = 8'h00;
    logic [7:0] sr1, sr2, sr3;
    logic       force1_en = 1'b0, force1_val = 1'b1;
    logic       force2_en = 1'b0, force2_val = 1'b1;
    logic       d1_b, d2_b, d3_b;
    int         edge_cnt = 0;
    int         f_edge_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    assign d1_b = force1_en ? force1_val : ~sr1[7];
    assign d2_b = force2_en ? force2_val : ~sr2[7];
    assign d3_b = ~sr3[7];

    // Controller models: parallel load while latch is high, shift on clk rise.
    always @(posedge ctl_clk or posedge ctl_latch)
        if (ctl_latch) begin sr1 <= m1_btn; sr2 <= m2_btn; end
        else begin sr1 <= {sr1[6:0], 1'b0}; sr2 <= {sr2[6:0], 1'b0}; end
    always @(posedge f_clk or posedge f_latch)
        if (f_latch) sr3 <= m3_btn;
        else sr3 <= {sr3[6:0], 1'b0};

    always @(posedge ctl_clk) edge_cnt++;
    always @(posedge f_clk) f_edge_cnt++;

    controller_poller_m u_dut (
        .clk_12_5875               (clk),
        .rst                       (rst),
        .start                     (start),
        .controller_clk            (ctl_clk),
        .controller_clk_out_enable (ctl_oe),
        .controller_latch          (ctl_latch),
        .controller_1_data_in_B    (d1_b),
        .controller_2_data_in_B    (d2_b),
        .controller_1_buttons_out  (btn1),
        .controller_2_buttons_out  (btn2),
        .busy                      (busy),
        .done                      (done)
    );

    controller_poller_m #(.HALF_PERIOD(4)) u_fast (
        .clk_12_5875               (clk),
        .rst                       (rst),
        .start                     (start_f),
        .controller_clk            (f_clk),
        .controller_clk_out_enable (f_oe),
        .controller_latch          (f_latch),
        .controller_1_data_in_B    (d3_b),
        .controller_2_data_in_B    (1'b1),
        .controller_1_buttons_out  (f_btn1),
        .controller_2_buttons_out  (f_btn2),
        .busy                      (f_busy),
        .done                      (f_done)
    );

    function automatic logic [7:0] bit8(input int unsigned pos);
        logic [7:0] one;
        one = 8'h01;
        return one << pos;
    endfunction

    // Runs one poll of the default-rate DUT over a fixed 180-cycle window.
    // start is high in cycle 0 and again in cycles again_a/b/c (if >0).
    task automatic run_poll(input int again_a, input int again_b, input int again_c,
                            output int done_at, output int n_done, output int n_latch,
                            output int n_edges, output bit held,
                            output logic [7:0] got1, output logic [7:0] got2);
        logic [7:0] prev1, prev2;
        int e0;
        prev1 = btn1; prev2 = btn2;
        done_at = -1; n_done = 0; n_latch = 0; held = 1'b1;
        got1 = 8'hxx; got2 = 8'hxx;
        @(posedge clk); #1;
        e0 = edge_cnt;
        start = 1'b1;
        for (int n = 1; n <= 180; n++) begin
            @(posedge clk); #1;
            start = (n == again_a) || (n == again_b) || (n == again_c);
            if (ctl_latch) n_latch++;
            if (done) begin
                n_done++;
                if (done_at < 0) begin done_at = n; got1 = btn1; got2 = btn2; end
            end else if (done_at < 0 && (btn1 !== prev1 || btn2 !== prev2)) begin
                held = 1'b0;
            end
        end
        start = 1'b0;
        n_edges = edge_cnt - e0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ctl_clk !== 1'b0) begin n_bad++; $display("FAIL reset_clk: got %b want 0", ctl_clk); end
        n_cmp++; if (ctl_latch !== 1'b0) begin n_bad++; $display("FAIL reset_latch: got %b want 0", ctl_latch); end
        n_cmp++; if (busy !== 1'b0 || ctl_oe !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, ctl_oe); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (btn1 !== 8'h00 || btn2 !== 8'h00) begin n_bad++; $display("FAIL reset_buttons: got %h/%h want 00/00", btn1, btn2); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int done_at, n_done, n_latch, n_edges; bit held;
        logic [7:0] g1, g2; logic [15:0] e;
        m1_btn = bit8(BTN_A) | bit8(BTN_SELECT) | bit8(BTN_DOWN) | bit8(BTN_RIGHT);
        m2_btn = bit8(BTN_SELECT) | bit8(BTN_START) | bit8(BTN_UP) | bit8(BTN_DOWN);
        exp_q.push_back({m1_btn, m2_btn});
        run_poll(-1, -1, -1, done_at, n_done, n_latch, n_edges, held, g1, g2);
        n_cmp++; if (done_at != 153) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 153", done_at); end
        n_cmp++; if (n_latch != 16) begin n_bad++; $display("FAIL basic_latch_cycles: got %0d want 16", n_latch); end
        n_cmp++; if (n_edges != 8) begin n_bad++; $display("FAIL basic_clk_edges: got %0d want 8", n_edges); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL basic_done_pulses: got %0d want 1", n_done); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL basic_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            if (g1 !== e[15:8] || g2 !== e[7:0]) begin n_bad++; $display("FAIL basic_buttons: got %h/%h want %h/%h", g1, g2, e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_hold_update();
        int done_at, n_done, n_latch, n_edges; bit held;
        logic [7:0] g1, g2; logic [15:0] e;
        m1_btn = 8'hFF; m2_btn = 8'h00;
        exp_q.push_back({m1_btn, m2_btn});
        run_poll(-1, -1, -1, done_at, n_done, n_latch, n_edges, held, g1, g2);
        n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL hold_before_done: got %b want 1", held); end
        n_cmp++; if (done_at != 153) begin n_bad++; $display("FAIL hold_done_cycle: got %0d want 153", done_at); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL hold_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            if (g1 !== e[15:8] || g2 !== e[7:0]) begin n_bad++; $display("FAIL hold_buttons: got %h/%h want %h/%h", g1, g2, e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_start_ignored();
        int done_at, n_done, n_latch, n_edges; bit held;
        logic [7:0] g1, g2; logic [15:0] e;
        m1_btn = bit8(BTN_B) | bit8(BTN_START) | bit8(BTN_UP) | bit8(BTN_LEFT);
        m2_btn = 8'hC3;
        exp_q.push_back({m1_btn, m2_btn});
        run_poll(20, 152, 153, done_at, n_done, n_latch, n_edges, held, g1, g2);
        n_cmp++; if (done_at != 153) begin n_bad++; $display("FAIL busy_start_done_cycle: got %0d want 153", done_at); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL busy_start_done_pulses: got %0d want 1", n_done); end
        n_cmp++; if (n_edges != 8) begin n_bad++; $display("FAIL busy_start_clk_edges: got %0d want 8", n_edges); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_no_restart: busy %b want 0", busy); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL busy_start_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            if (g1 !== e[15:8] || g2 !== e[7:0]) begin n_bad++; $display("FAIL busy_start_buttons: got %h/%h want %h/%h", g1, g2, e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_reset_mid_poll();
        int done_at, n_done, n_latch, n_edges, nd; bit held;
        logic [7:0] g1, g2; logic [15:0] e;
        m1_btn = 8'h81; m2_btn = 8'h7E;
        @(posedge clk); #1;
        start = 1'b1;
        for (int n = 1; n <= 90; n++) begin @(posedge clk); #1; start = 1'b0; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ctl_clk !== 1'b0 || ctl_latch !== 1'b0) begin n_bad++; $display("FAIL midrst_pads: clk/latch %b/%b want 0/0", ctl_clk, ctl_latch); end
        n_cmp++; if (busy !== 1'b0 || ctl_oe !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b/%b want 0/0", busy, ctl_oe); end
        n_cmp++; if (btn1 !== 8'h00 || btn2 !== 8'h00) begin n_bad++; $display("FAIL midrst_buttons: got %h/%h want 00/00", btn1, btn2); end
        rst = 1'b0;
        nd = 0;
        for (int n = 0; n < 170; n++) begin @(posedge clk); #1; if (done) nd++; end
        n_cmp++; if (nd != 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", nd); end
        exp_q.push_back({m1_btn, m2_btn});
        run_poll(-1, -1, -1, done_at, n_done, n_latch, n_edges, held, g1, g2);
        n_cmp++; if (done_at != 153) begin n_bad++; $display("FAIL midrst_fresh_done_cycle: got %0d want 153", done_at); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL midrst_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            if (g1 !== e[15:8] || g2 !== e[7:0]) begin n_bad++; $display("FAIL midrst_fresh_buttons: got %h/%h want %h/%h", g1, g2, e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_stuck_inputs();
        int done_at, n_done, n_latch, n_edges; bit held;
        logic [7:0] g1, g2; logic [15:0] e;
        force1_en = 1'b1; force1_val = 1'b0;
        force2_en = 1'b1; force2_val = 1'b1;
        exp_q.push_back({8'hFF, 8'h00});
        run_poll(-1, -1, -1, done_at, n_done, n_latch, n_edges, held, g1, g2);
        force1_en = 1'b0; force2_en = 1'b0;
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL stuck_done_pulses: got %0d want 1", n_done); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL stuck_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            if (g1 !== e[15:8] || g2 !== e[7:0]) begin n_bad++; $display("FAIL stuck_buttons: got %h/%h want %h/%h", g1, g2, e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_fast();
        int done_at, e0;
        logic [7:0] g1; logic [15:0] e;
        m3_btn = bit8(BTN_START);
        exp_q.push_back({m3_btn, 8'h00});
        done_at = -1; g1 = 8'hxx;
        @(posedge clk); #1;
        e0 = f_edge_cnt;
        start_f = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            start_f = 1'b0;
            if (f_done && done_at < 0) begin done_at = n; g1 = f_btn1; end
        end
        n_cmp++; if (done_at != 77) begin n_bad++; $display("FAIL fast_done_cycle: got %0d want 77", done_at); end
        n_cmp++; if (f_edge_cnt - e0 != 8) begin n_bad++; $display("FAIL fast_clk_edges: got %0d want 8", f_edge_cnt - e0); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL fast_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            if (g1 !== e[15:8] || f_btn2 !== e[7:0]) begin n_bad++; $display("FAIL fast_buttons: got %h/%h want %h/%h", g1, f_btn2, e[15:8], e[7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_update();
        test_start_ignored();
        test_reset_mid_poll();
        test_stuck_inputs();
        test_fast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controller_poller_m.md
Name: controller_poller_m

Overview:
- Host-side end of the serial gamepad link. It is the reader that drives latch and clock into two shift-register controllers (controller_m) and collects their 8 button bits each.
- Sits inside top_m, between the controller pins and the CPU-visible controller registers.
- A poll is started by a one-cycle `start` pulse, normally issued at vblank.
- At the end of each poll, both button bytes are committed atomically.

Parameters:
- HALF_PERIOD, 8: system clock cycles per half period of controller_clk. Legal range is 4..255; elaborate-time check rejects values outside it.
- LATCH_HALVES, 2: number of half periods for which controller_latch stays high.

Ports:
- clk_12_5875  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle poll request.
- controller_clk  out  1  serial shift clock to both controllers; idles low.
- controller_clk_out_enable  out  1  pad driver enable for controller_clk and controller_latch; equals busy.
- controller_latch  out  1  parallel-load strobe; high loads the controller shift registers.
- controller_1_data_in_B  in  1  serial data from controller 1, active-low (0 = pressed).
- controller_2_data_in_B  in  1  serial data from controller 2, active-low.
- controller_1_buttons_out  out  8  last committed byte for controller 1, active-high (1 = pressed).
- controller_2_buttons_out  out  8  last committed byte for controller 2, active-high.
- busy  out  1  a poll is in progress.
- done  out  1  one-cycle pulse on the cycle the button bytes are committed.

Behaviour:
- Reset values:
  - controller_clk, controller_latch, busy, done, controller_clk_out_enable all 0.
  - Both buttons_out 8'h00.
  - Sync flops 1.
  - State IDLE; counters 0.
- Input synchronisation: each data_in_B passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Half-period counter: counts 0..HALF_PERIOD-1 while busy and is held at 0 in IDLE. The last count value is the "tick".
- States:
  - IDLE: `start` moves to LATCH on the next cycle. busy rises on the same edge.
  - LATCH: controller_latch=1 for LATCH_HALVES*HALF_PERIOD cycles, then → GAP.
  - GAP: latch=0, clk=0 for HALF_PERIOD cycles; bit 0 is now stable. Then → LOW with bit index 0.
  - LOW: clk=0 for HALF_PERIOD cycles. On the tick cycle, sample both synchronised inputs, invert them, and shift left into shadow registers (new bit enters at LSB), so the first serial bit ends in bit 7. Then → HIGH.
  - HIGH: clk=1 for HALF_PERIOD cycles; the rising edge advances the controllers. On the tick, if bit index=7 → COMMIT, else increment the index and → LOW.
  - COMMIT: one cycle. Copy shadows to buttons_out, pulse done=1, drop busy and clk_out_enable, → IDLE.
- Timing: with `start` sampled at cycle 0, done=1 at cycle 1+(LATCH_HALVES+1+16)*HALF_PERIOD, which is 153 for the defaults. Exactly 8 controller_clk rising edges occur per poll.
- buttons_out change only in COMMIT and hold their value between polls. Partial shadows are never visible.
- `start` while busy (including during the COMMIT cycle) is ignored and not queued.
- rst mid-poll: all outputs return to reset values on the next edge, buttons_out are cleared, and no done pulse is issued.
- An unplugged controller (input held 1 by pull-up) reads 8'h00. A stuck-low input reads 8'hFF.
- The bit index is 3 bits; no wrap beyond 7 is possible because COMMIT is entered at index 7.

Decomposition:
- Shared package controller_pkg:
  - State enum (IDLE, LATCH, GAP, LOW, HIGH, COMMIT).
  - Button bit positions: A=7, B=6, SELECT=5, START=4, UP=3, DOWN=2, LEFT=1, RIGHT=0.
  - Parameter range limits.
- Sub-module sync2_m: 2-flop synchroniser with reset value parameter, instantiated once per data input.

Test Plan:
- Default params; controller_m models loaded with 8'hA5 and 8'h3C; pulse start → latch high 16 cycles; 8 clock pulses of 16 cycles each; done at cycle 153; buttons_out = 8'hA5 / 8'h3C.
- Change models to 8'hFF / 8'h00, poll again → outputs hold A5/3C until done, then read FF/00 in the same cycle.
- Pulse start again at cycles 20 and 152 of a poll → no restart; exactly one done pulse; 8 clk edges counted.
- Assert rst at cycle 90 of a poll → next edge clk=0, latch=0, busy=0, buttons=00; no done pulse; a fresh start then completes normally.
- Tie controller_2_data_in_B to 1 and controller_1_data_in_B to 0 → buttons_out 8'hFF / 8'h00.
- HALF_PERIOD=4: start then a single press of START on controller 1 → done at cycle 77; controller_1_buttons_out = 8'h10.
